// File: rtl/conv_window_addr_seq.sv
// conv_window_addr_seq
//   Sliding-window address sequencer. Walks a KxK kernel window with stride 1
//   over a W x H row-major feature map and hands one pixel address per
//   valid/ready handshake to the pixel fetch stage.
//
// Ports
//   COUNTER_Clk     clock, all state on rising edge
//   COUNTER_Clr     asynchronous active-low reset
//   SEQ_Start       start pulse, only honoured in IDLE
//   SEQ_Img_W/H     image width/height, latched on an accepted start
//   SEQ_Ready       downstream accepts the current address
//   SEQ_Addr        (oy+ky)*W + (ox+kx)
//   SEQ_Valid       SEQ_Addr valid (high throughout RUN)
//   SEQ_Win_Last    current beat is the last pixel of a window
//   SEQ_Frame_Last  current beat is the last pixel of the last window
//   SEQ_Busy        high in LOAD and RUN
//   SEQ_Done        one-cycle pulse at end of frame or rejected frame
//   SEQ_Err         last start rejected (W<K or H<K), held until next start
module conv_window_addr_seq #(
  parameter int BITWIDTH = 10,
  parameter int ADDR_W   = 20,
  parameter int K        = 3
) (
  input  logic                COUNTER_Clk,
  input  logic                COUNTER_Clr,
  input  logic                SEQ_Start,
  input  logic [BITWIDTH-1:0] SEQ_Img_W,
  input  logic [BITWIDTH-1:0] SEQ_Img_H,
  input  logic                SEQ_Ready,
  output logic [ADDR_W-1:0]   SEQ_Addr,
  output logic                SEQ_Valid,
  output logic                SEQ_Win_Last,
  output logic                SEQ_Frame_Last,
  output logic                SEQ_Busy,
  output logic                SEQ_Done,
  output logic                SEQ_Err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [BITWIDTH-1:0] K_SIDE = BITWIDTH'(K);
  localparam logic [BITWIDTH-1:0] K_LAST = BITWIDTH'(K - 1);

  state_t state, state_nxt;

  logic [BITWIDTH-1:0] img_w, img_h;
  logic [BITWIDTH-1:0] kx, ky, ox, oy;
  logic                err;

  logic                xfer, too_small, cnt_clr;
  logic                kx_last, ky_last, ox_last, oy_last;
  logic                kx_en, ky_en, ox_en, oy_en;
  logic [BITWIDTH:0]   row_sum, col_sum;
  logic [ADDR_W-1:0]   addr_calc;

  // Equality flags against the run-time limits; the last window origin is
  // W-K / H-K, which is only meaningful once the frame has passed the size
  // check in LOAD.
  always_comb begin
    kx_last   = (kx == K_LAST);
    ky_last   = (ky == K_LAST);
    ox_last   = (ox == img_w - K_SIDE);
    oy_last   = (oy == img_h - K_SIDE);
    too_small = (img_w < K_SIDE) || (img_h < K_SIDE);
    xfer      = (state == RUN) && SEQ_Ready;
    cnt_clr   = (state == LOAD);
    // Nested enables: each counter steps only when every inner one wraps.
    kx_en     = xfer;
    ky_en     = kx_en && kx_last;
    ox_en     = ky_en && ky_last;
    oy_en     = ox_en && ox_last;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (SEQ_Start) state_nxt = LOAD;
      LOAD:    state_nxt = too_small ? DONE : RUN;
      RUN:     if (xfer && SEQ_Frame_Last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge COUNTER_Clk or negedge COUNTER_Clr) begin
    if (!COUNTER_Clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Image size is captured only on an accepted start so that later changes
  // on SEQ_Img_W/H cannot disturb a frame in flight.
  always_ff @(posedge COUNTER_Clk or negedge COUNTER_Clr) begin
    if (!COUNTER_Clr) begin
      img_w <= '0;
      img_h <= '0;
      err   <= 1'b0;
    end else begin
      if (state == IDLE && SEQ_Start) begin
        img_w <= SEQ_Img_W;
        img_h <= SEQ_Img_H;
        err   <= 1'b0;
      end else if (state == LOAD && too_small) begin
        err   <= 1'b1;
      end
    end
  end

  // Window position counters: clear in LOAD, wrap at their limit on enable.
  always_ff @(posedge COUNTER_Clk or negedge COUNTER_Clr) begin
    if (!COUNTER_Clr) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (cnt_clr) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else begin
      if (kx_en) kx <= kx_last ? '0 : kx + 1'b1;
      if (ky_en) ky <= ky_last ? '0 : ky + 1'b1;
      if (ox_en) ox <= ox_last ? '0 : ox + 1'b1;
      if (oy_en) oy <= oy_last ? '0 : oy + 1'b1;
    end
  end

  // Address arithmetic; sums carry one extra bit, product zero-extended.
  always_comb begin
    row_sum   = {1'b0, oy} + {1'b0, ky};
    col_sum   = {1'b0, ox} + {1'b0, kx};
    addr_calc = ADDR_W'(row_sum) * ADDR_W'(img_w) + ADDR_W'(col_sum);
  end

  // Outputs depend on registered state only; address and flags are forced
  // to zero outside RUN so idle outputs are clean.
  always_comb begin
    SEQ_Valid      = (state == RUN);
    SEQ_Busy       = (state == LOAD) || (state == RUN);
    SEQ_Done       = (state == DONE);
    SEQ_Err        = err;
    SEQ_Addr       = SEQ_Valid ? addr_calc : '0;
    SEQ_Win_Last   = SEQ_Valid && kx_last && ky_last;
    SEQ_Frame_Last = SEQ_Win_Last && ox_last && oy_last;
  end

endmodule
